// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage pipeline register chain with valid/ready ends, per-stage
// hold (bubble insertion) and flush (squash), bubble collapse and status counters.
module pipe_stage_chain #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    input  logic [DEPTH-1:0]             hold,
    input  logic [DEPTH-1:0]             flush,
    output logic [DEPTH-1:0]             valid_vec,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [STALL_CNT_W-1:0]       stall_cnt
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]       v_r;
    logic [WIDTH-1:0]       data_r [DEPTH];
    logic [OCC_W-1:0]       occupancy_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic [DEPTH-1:0]       adv_s;
    logic [DEPTH-1:0]       v_next_s;
    logic                   stall_s;

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] vec);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + OCC_W'(vec[i]);
        end
        return cnt;
    endfunction

    // Advance chain: a stage moves when it is empty or its successor moves, unless held.
    always_comb begin
        logic carry;
        adv_s = '0;
        carry = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv_s[i] = (!v_r[i] | carry) & !hold[i];
            carry    = adv_s[i];
        end
    end

    // Next valid bits: flush beats advance; a held predecessor hands over a bubble.
    always_comb begin
        v_next_s = v_r;
        if (flush[0]) begin
            v_next_s[0] = 1'b0;
        end else if (adv_s[0]) begin
            v_next_s[0] = in_valid;
        end else begin
            v_next_s[0] = v_r[0];
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (flush[i]) begin
                v_next_s[i] = 1'b0;
            end else if (adv_s[i]) begin
                v_next_s[i] = v_r[i-1] & !hold[i-1];
            end else begin
                v_next_s[i] = v_r[i];
            end
        end
    end

    assign stall_s = in_valid & !adv_s[0];

    // Stage valid bits and occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r         <= '0;
            occupancy_r <= '0;
        end else begin
            v_r         <= v_next_s;
            occupancy_r <= popcount(v_next_s);
        end
    end

    // Stage payloads; a flushed stage keeps stale data behind a cleared valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            if (!flush[0] && adv_s[0]) begin
                data_r[0] <= in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (!flush[i] && adv_s[i]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
        end
    end

    // Saturating count of cycles where upstream offered data but was refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1'b1);
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = v_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
    assign valid_vec = v_r;
    assign occupancy = occupancy_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios then random
// traffic, compared each cycle against a slot-level reference model.
module tb_pipe_stage_chain;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [D-1:0]  hold;
    logic [D-1:0]  flush;
    logic [D-1:0]  valid_vec;
    logic [2:0]    occupancy;
    logic [SW-1:0] stall_cnt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: slot contents and the saturating stall count
    logic [D-1:0] m_v;
    logic [W-1:0] m_d [D];
    int           m_stall;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .hold(hold), .flush(flush),
        .valid_vec(valid_vec), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_v = '0;
        for (int i = 0; i < D; i++) m_d[i] = '0;
        m_stall = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":valid_vec"}, valid_vec, m_v);
        chk({tag, ":occupancy"}, occupancy, $countones(m_v));
        chk({tag, ":stall_cnt"}, stall_cnt, m_stall);
    endtask

    // One clock cycle: drive inputs, check handshake mid-cycle, step model, check state.
    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                         input logic [D-1:0] h, input logic [D-1:0] f);
        logic [D-1:0] mv;
        logic [D-1:0] nv;
        logic [W-1:0] nd [D];
        logic         leaves;
        in_valid = iv; in_data = id; out_ready = ordy; hold = h; flush = f;
        @(negedge clk);
        // A slot can take new content if it is empty or its occupant moves on
        leaves = ordy;
        for (int i = D - 1; i >= 0; i--) begin
            mv[i]  = (!m_v[i] || leaves) && !h[i];
            leaves = mv[i];
        end
        chk("in_ready", in_ready, mv[0]);
        chk("out_valid", out_valid, m_v[D-1]);
        if (m_v[D-1]) chk("out_data", out_data, m_d[D-1]);
        nv = m_v;
        for (int i = 0; i < D; i++) nd[i] = m_d[i];
        if (mv[0]) begin
            nv[0] = iv;
            nd[0] = id;
        end
        for (int i = 1; i < D; i++) begin
            if (mv[i]) begin
                nv[i] = mv[i-1] ? m_v[i-1] : 1'b0;
                nd[i] = m_d[i-1];
            end
        end
        nv = nv & ~f;
        if (iv && !mv[0] && m_stall < (1 << SW) - 1) m_stall++;
        @(posedge clk);
        #1;
        m_v = nv;
        for (int i = 0; i < D; i++) m_d[i] = nd[i];
        check_state("cyc");
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        hold = '0; flush = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check_state("reset");
        chk("reset:out_valid", out_valid, 1'b0);
        chk("reset:out_data", out_data, 16'h0000);
        chk("reset:in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming at full rate, then drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0010 + 16'(i), 1'b1, 4'b0000, 4'b0000);
        chk("stream:occ_peak", occupancy, 3'd4);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b1, 4'b0000, 4'b0000);

        // Hold: fill B0..B3 blocked, then stall stage 1 for one cycle while draining
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h00B0 + 16'(i), 1'b0, 4'b0000, 4'b0000);
        cycle(1'b1, 16'h00BF, 1'b1, 4'b0010, 4'b0000);
        chk("hold:valid_vec", valid_vec, 4'b1011);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b1, 4'b0000, 4'b0000);

        // Flush: C3,C2 parked in stages 3,2; C4 accepted in the same cycle as flush of 0-1
        cycle(1'b1, 16'h00C3, 1'b0, 4'b0000, 4'b0000);
        cycle(1'b1, 16'h00C2, 1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000);
        cycle(1'b0, 16'h0000, 1'b0, 4'b0000, 4'b0000);
        chk("flush:pre", valid_vec, 4'b1100);
        cycle(1'b1, 16'h00C4, 1'b0, 4'b0000, 4'b0011);
        chk("flush:post", valid_vec, 4'b1100);
        for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 4'b0000, 4'b0000);

        // Backpressure and stall counter saturation
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h00A0 + 16'(i), 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) cycle(1'b1, 16'h00AF, 1'b0, 4'b0000, 4'b0000);
        chk("sat:stall_cnt", stall_cnt, 4'd15);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0000, 1'b1, 4'b0000, 4'b0000);

        // Asynchronous reset with three payloads in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h00D0 + 16'(i), 1'b0, 4'b0000, 4'b0000);
        chk("prerst:occupancy", occupancy, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_state("asyncrst");
        chk("asyncrst:out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        cycle(1'b1, 16'h00E1, 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1, 4'b0000, 4'b0000);
        chk("latency:out_valid", out_valid, 1'b1);
        chk("latency:out_data", out_data, 16'h00E1);
        cycle(1'b0, 16'h0000, 1'b1, 4'b0000, 4'b0000);

        // Random traffic with sparse holds and flushes
        for (int n = 0; n < 400; n++) begin
            logic [D-1:0] h;
            logic [D-1:0] f;
            for (int i = 0; i < D; i++) begin
                h[i] = ($urandom_range(0, 7) == 0);
                f[i] = ($urandom_range(0, 15) == 0);
            end
            cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0), h, f);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
